// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter that frames one requester word at a time as a header byte plus
// MSB-first payload bytes onto a single valid/ready UART byte interface.
module uart_tx_scheduler #(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned CHALLENGE_BIT = 32,
    parameter logic [3:0]  HDR_TAG       = 4'hA
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  logic [NUM_REQ*CHALLENGE_BIT-1:0]   req_data,
    output logic [NUM_REQ-1:0]                 req_ready,
    output logic [7:0]                         tx_data,
    output logic                               tx_data_valid,
    input  logic                               tx_data_ready,
    output logic                               busy,
    output logic [3:0]                         grant_id
);

    localparam int unsigned NBYTES = CHALLENGE_BIT / 8;
    localparam int unsigned CntW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {StIdle, StHdr, StPay} state_e;

    state_e                   state_q, state_d;
    logic [3:0]               rr_ptr_q, rr_ptr_d;
    logic [3:0]               grant_q, grant_d;
    logic [CntW-1:0]          byte_cnt_q, byte_cnt_d;
    logic [CHALLENGE_BIT-1:0] word_q, word_d;
    logic [NUM_REQ-1:0]       req_ready_q, req_ready_d;

    logic                     found, found_hi;
    logic [3:0]               winner, winner_hi, winner_lo;
    logic [CHALLENGE_BIT-1:0] word_sel;
    logic [7:0]               pay_byte;
    logic                     xfer, last_byte;

    assign xfer      = tx_data_valid && tx_data_ready;
    assign last_byte = (32'(byte_cnt_q) == NBYTES - 1);

    // Lowest set bit at or above rr_ptr wins; otherwise wrap to the lowest set bit overall.
    always_comb begin
        found     = 1'b0;
        found_hi  = 1'b0;
        winner_hi = '0;
        winner_lo = '0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                found     = 1'b1;
                winner_lo = 4'(i);
                if (i >= int'(rr_ptr_q)) begin
                    found_hi  = 1'b1;
                    winner_hi = 4'(i);
                end
            end
        end
        winner = found_hi ? winner_hi : winner_lo;
    end

    always_comb begin
        word_sel = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (4'(i) == winner) word_sel = req_data[i*CHALLENGE_BIT +: CHALLENGE_BIT];
        end
    end

    always_comb begin
        pay_byte = '0;
        for (int b = 0; b < int'(NBYTES); b++) begin
            if (CntW'(b) == byte_cnt_q) pay_byte = word_q[(int'(NBYTES) - 1 - b)*8 +: 8];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (found) state_d = StHdr;
            StHdr:   if (xfer) state_d = StPay;
            StPay:   if (xfer && last_byte) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        tx_data       = 8'h00;
        tx_data_valid = 1'b0;
        busy          = (state_q != StIdle);
        unique case (state_q)
            StHdr: begin
                tx_data       = {HDR_TAG, grant_q};
                tx_data_valid = 1'b1;
            end
            StPay: begin
                tx_data       = pay_byte;
                tx_data_valid = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        byte_cnt_d  = byte_cnt_q;
        word_d      = word_q;
        req_ready_d = '0;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    word_d      = word_sel;
                    grant_d     = winner;
                    req_ready_d = NUM_REQ'(1) << winner;
                end
            end
            StHdr: if (xfer) byte_cnt_d = '0;
            StPay: begin
                if (xfer) begin
                    if (last_byte) begin
                        rr_ptr_d = (grant_q == 4'(NUM_REQ - 1)) ? 4'd0 : grant_q + 4'd1;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            byte_cnt_q  <= '0;
            word_q      <= '0;
            req_ready_q <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            byte_cnt_q  <= byte_cnt_d;
            word_q      <= word_d;
            req_ready_q <= req_ready_d;
        end
    end

    assign req_ready = req_ready_q;
    assign grant_id  = grant_q;

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Round-robin scheduler that shares the single `modify_Uart_tx` byte transmitter between NUM_REQ requesters. Each requester offers one CHALLENGE_BIT-wide word. The scheduler grants one requester at a time and captures its word. It then sends a header byte tagging the requester, followed by the word bytes MSB-first, over the UART's valid/ready byte interface. The block sits between the challenge/response sources and `modify_Uart_tx`.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters; legal range 1..16.
- CHALLENGE_BIT, 32, word width per requester; a multiple of 8, legal range 8..128.
- HDR_TAG, 4'hA, upper nibble of every header byte.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  bit i high = requester i has a word pending.
- req_data  input  NUM_REQ*CHALLENGE_BIT  word i occupies bits [i*CHALLENGE_BIT +: CHALLENGE_BIT].
- req_ready  output  NUM_REQ  one-cycle pulse on bit i when word i has been captured.
- tx_data  output  8  byte to the UART.
- tx_data_valid  output  1  tx_data is valid.
- tx_data_ready  input  1  UART accepts the byte; a transfer occurs on any edge where tx_data_valid && tx_data_ready.
- busy  output  1  high in any state other than IDLE.
- grant_id  output  4  index of the requester currently being sent.

## Operation
- NBYTES = CHALLENGE_BIT/8. Internal state:
  - rr_ptr, 4 bits;
  - byte_cnt, wide enough for NBYTES-1;
  - a CHALLENGE_BIT word register;
  - FSM with states IDLE, HDR, PAY.
- IDLE:
  - tx_data_valid = 0.
  - If any req_valid bit is set, pick the first set bit scanning rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - On that edge: capture the winner's word, set grant_id = winner, pulse req_ready[winner] for the next cycle only, and go to HDR.
- HDR:
  - tx_data = {HDR_TAG, grant_id}, tx_data_valid = 1.
  - On transfer: byte_cnt = 0, go to PAY.
- PAY:
  - tx_data = word byte NBYTES-1-byte_cnt (MSB first), tx_data_valid = 1.
  - On transfer with byte_cnt == NBYTES-1: go to IDLE and set rr_ptr = (grant_id+1) mod NUM_REQ.
  - On any other transfer: byte_cnt += 1.
- Round-robin gives strict fairness. A continuously asserted requester cannot block the others; its worst-case wait is NUM_REQ-1 packets.
- The captured word is frozen. Changes on req_data or req_valid after capture do not affect the packet in flight.
- A req_valid bit that drops before it is granted is simply skipped. No state is kept per requester.
- tx_data_ready while tx_data_valid = 0 is ignored.

## Timing
- Reset values, applied asynchronously and held while reset is high:
  - FSM = IDLE, rr_ptr = 0, byte_cnt = 0, word register = 0;
  - tx_data = 8'h00, tx_data_valid = 0, req_ready = 0, busy = 0, grant_id = 0.
- Grant latency: a request seen in IDLE at edge N gives req_ready, busy and tx_data_valid all high in cycle N+1 (registered outputs).
- While tx_data_valid = 1 and tx_data_ready = 0, tx_data holds stable.
- Within a packet, bytes go back-to-back. The byte after a transfer at edge M is presented in cycle M+1.
- Between packets, tx_data_valid is low for exactly one cycle (the IDLE cycle), even if requests are pending.
- Packet length is 1+NBYTES transfers. Minimum packet time is 2+NBYTES cycles from grant to IDLE when tx_data_ready is held at 1.
- Reset mid-packet:
  - all outputs return to their reset values immediately;
  - the captured word is discarded and not retransmitted;
  - after release, arbitration restarts from rr_ptr = 0.
- NUM_REQ = 1: rr_ptr stays 0 and arbitration reduces to request 0 only.

## Test plan
- Single request, ready tied to 1: req_valid = 4'b0001, word0 = 32'h12345678. Expected: req_ready = 4'b0001 for one cycle, then bytes A0, 12, 34, 56, 78 on consecutive cycles; busy falls after 78.
- Simultaneous requests: all four valid with words 32'h0000_00i0. Expected: headers A0, A1, A2, A3 in order, then rr_ptr wraps to 0; one-cycle valid gap between packets.
- Backpressure: tx_data_ready low for 50 cycles during PAY. Expected: tx_data constant and tx_data_valid high throughout; transfer completes on the first ready cycle.
- Fairness: req_valid[0] and req_valid[2] held high continuously. Expected: headers alternate A0, A2, A0, A2; requester 2 is never skipped.
- Reset mid-payload: assert reset after the second payload byte. Expected: tx_data_valid = 0 and busy = 0 in the same cycle; after release, with req_valid = 4'b0010, the next header is A1.
- Word change after capture: change req_data for requester 0 in the cycle after req_ready. Expected: the originally captured bytes are transmitted unchanged.
